// File: rtl/prng_pkg.sv
// Shared definitions for the entropy-mixing PRNG: default constants, FSM
// encoding and the Galois LFSR step with entropy injection and zero-lock guard.
package prng_pkg;

  localparam int unsigned LFSR_MAX_W = 64;

  localparam int unsigned DEF_WIDTH = 16;
  localparam logic [15:0] DEF_TAPS  = 16'h002D;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_READY    = 2'd1,
    ST_RECHARGE = 2'd2
  } prng_state_e;

  // Operates on a LFSR_MAX_W container so any WIDTH up to 64 can share it;
  // bits above width are masked off and must be ignored by the caller.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic                  e_bit,
    input logic [LFSR_MAX_W-1:0] taps,
    input logic [LFSR_MAX_W-1:0] seed,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] t;
    logic                  fb;
    mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
    fb   = |(s & (LFSR_MAX_W'(1) << (width - 1)));
    t    = ((s << 1) ^ (fb ? taps : '0) ^ LFSR_MAX_W'(e_bit)) & mask;
    return (t == '0) ? (seed & mask) : t;
  endfunction

endpackage

// File: rtl/lfsr_absorb.sv
// LFSR state register: absorbs one entropy bit per cycle, with reseed load
// and zero-lock protection on both the step and the reseed value.
module lfsr_absorb
  import prng_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_bit,
  input  logic             reseed,
  input  logic [WIDTH-1:0] reseed_word,
  output logic [WIDTH-1:0] s_next
);

  logic [WIDTH-1:0] s;

  assign s_next = WIDTH'(lfsr_step(LFSR_MAX_W'(s), e_bit, LFSR_MAX_W'(TAPS),
                                   LFSR_MAX_W'(SEED), WIDTH));

  // The e_bit of a reseed cycle is intentionally dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= SEED;
    end else if (reseed) begin
      s <= (reseed_word == '0) ? SEED : reseed_word;
    end else begin
      s <= s_next;
    end
  end

endmodule

// File: rtl/entropy_prng.sv
// Per-lane PRNG: wraps the entropy-absorbing LFSR with warm-up/recharge
// pacing and a registered valid/ready word output.
module entropy_prng
  import prng_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
  parameter int               WARMUP = 16,
  parameter int               GAP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_bit,
  input  logic             reseed,
  input  logic [WIDTH-1:0] reseed_word,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_word,
  output logic             warm
);

  localparam int CNT_MAX = (WARMUP > GAP) ? WARMUP : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  prng_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             valid_nx, warm_nx;
  logic [WIDTH-1:0] word_nx;
  logic [WIDTH-1:0] s_next;

  lfsr_absorb #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .e_bit       (e_bit),
    .reseed      (reseed),
    .reseed_word (reseed_word),
    .s_next      (s_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_WARMUP;
      cnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_word  <= '0;
      warm      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rnd_valid <= valid_nx;
      rnd_word  <= word_nx;
      warm      <= warm_nx;
    end
  end

  // Reseed overrides everything; a transfer in the same cycle is simply
  // treated as done because the consumer already sampled rnd_word.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    valid_nx = rnd_valid;
    word_nx  = rnd_word;
    warm_nx  = warm;
    if (reseed) begin
      state_nx = ST_WARMUP;
      cnt_nx   = '0;
      valid_nx = 1'b0;
      warm_nx  = 1'b0;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (cnt == WARM_LAST) begin
            word_nx  = s_next;
            valid_nx = 1'b1;
            warm_nx  = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_READY;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (rnd_ready) begin
            valid_nx = 1'b0;
            cnt_nx   = '0;
            state_nx = ST_RECHARGE;
          end
        end
        ST_RECHARGE: begin
          if (cnt == GAP_LAST) begin
            word_nx  = s_next;
            valid_nx = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_READY;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = ST_WARMUP;
          cnt_nx   = '0;
          valid_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_prng.sv
// Bench for entropy_prng: WARMUP=1 vector table plus a scoreboarded
// reference model of the default-parameter instance.
module tb_entropy_prng;
  import prng_pkg::*;

  localparam int WARM_CYC = 16;
  localparam int GAP_CYC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e_bit = 1'b0;
  logic        reseed = 1'b0;
  logic [15:0] reseed_word = 16'h0000;
  logic        rnd_ready = 1'b0;

  logic        rnd_valid, warm, w1_valid, w1_warm;
  logic [15:0] rnd_word, w1_word;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_s     = 16'hACE1;
  logic [15:0] m_word  = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_warm  = 1'b0;
  int          m_wait  = WARM_CYC;
  logic [15:0] exp_q[$];

  entropy_prng dut (
    .clk(clk), .rst(rst), .e_bit(e_bit), .reseed(reseed),
    .reseed_word(reseed_word), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .rnd_word(rnd_word), .warm(warm)
  );

  entropy_prng #(.WARMUP(1)) dut_w1 (
    .clk(clk), .rst(rst), .e_bit(e_bit), .reseed(reseed),
    .reseed_word(reseed_word), .rnd_valid(w1_valid), .rnd_ready(rnd_ready),
    .rnd_word(w1_word), .warm(w1_warm)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic e);
    logic [15:0] t;
    t = {s[14:0], e};
    if (s[15]) t = t ^ 16'h002D;
    return (t == 16'h0000) ? 16'hACE1 : t;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic rs, input logic [15:0] rw, input logic rdy);
    @(negedge clk);
    #1;
    e_bit       = e;
    reseed      = rs;
    reseed_word = rw;
    rnd_ready   = rdy;
  endtask

  // Counts clock edges until the default instance shows rnd_valid.
  task automatic countToValid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      e_bit = 1'($urandom);
      n++;
    end while (!rnd_valid && n < limit);
    if (!rnd_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_valid: no rnd_valid within %0d cycles", limit);
    end
  endtask

  // Reference model of the default instance, advanced on the same edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s     <= 16'hACE1;
      m_wait  <= WARM_CYC;
      m_valid <= 1'b0;
      m_word  <= 16'h0000;
      m_warm  <= 1'b0;
      exp_q.delete();
    end else if (reseed) begin
      if (m_valid && !rnd_ready && exp_q.size() > 0) void'(exp_q.pop_back());
      m_s     <= (reseed_word == 16'h0000) ? 16'hACE1 : reseed_word;
      m_valid <= 1'b0;
      m_warm  <= 1'b0;
      m_wait  <= WARM_CYC;
    end else begin
      m_s <= ref_step(m_s, e_bit);
      if (m_valid && rnd_ready) begin
        m_valid <= 1'b0;
        m_wait  <= GAP_CYC;
      end else if (!m_valid) begin
        if (m_wait == 1) begin
          m_word  <= ref_step(m_s, e_bit);
          m_valid <= 1'b1;
          m_warm  <= 1'b1;
          exp_q.push_back(ref_step(m_s, e_bit));
        end else begin
          m_wait <= m_wait - 1;
        end
      end
    end
  end

  // Sampled after inputs settle and before the next rising edge.
  always @(negedge clk) begin
    #3;
    checkOutput("sb_valid", 16'(rnd_valid), 16'(m_valid));
    checkOutput("sb_warm", 16'(warm), 16'(m_warm));
    checkOutput("sb_held_word", rnd_word, m_word);
    checkOutput("sb_lfsr_state", dut.u_lfsr.s, m_s);
    if (!rst && rnd_valid && rnd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb_transfer: got word %h, expected none pending", rnd_word);
      end else begin
        checkOutput("sb_transfer", rnd_word, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        use_reseed;
    logic [15:0] rw;
    logic        e;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h59EF};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h59EE};
    vecs[2] = '{1'b1, 16'h0000, 1'b0, 16'h59EF};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 16'h2468};
    vecs[4] = '{1'b1, 16'h1234, 1'b1, 16'h2469};
    vecs[5] = '{1'b1, 16'h8000, 1'b0, 16'h002D};
    vecs[6] = '{1'b1, 16'h8016, 1'b1, 16'hACE1};
    vecs[7] = '{1'b1, 16'h0001, 1'b1, 16'h0003};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].use_reseed) begin
        @(negedge clk);
        #1;
        rst = 1'b1; e_bit = vecs[i].e; reseed = 1'b0; rnd_ready = 1'b0;
        #1;
        rst = 1'b0;
      end else begin
        applyStimulus(1'b1, 1'b1, vecs[i].rw, 1'b0);
        applyStimulus(vecs[i].e, 1'b0, 16'h0000, 1'b0);
        checkOutput("w1_valid_after_reseed", 16'(w1_valid), 16'h0000);
        checkOutput("w1_warm_after_reseed", 16'(w1_warm), 16'h0000);
      end
      applyStimulus(vecs[i].e, 1'b0, 16'h0000, 1'b0);
      checkOutput("w1_valid", 16'(w1_valid), 16'h0001);
      checkOutput("w1_word", w1_word, vecs[i].exp_word);
      checkOutput("w1_warm", 16'(w1_warm), 16'h0001);
    end

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    countToValid(40, n);
    checkOutput("first_valid_latency", 16'(n), 16'(WARM_CYC));
    for (int k = 0; k < 3; k++) begin
      countToValid(20, n);
      checkOutput("gap_interval", 16'(n), 16'(GAP_CYC + 1));
    end

    rnd_ready = 1'b0;
    countToValid(20, n);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'($urandom), 1'b0, 16'h0000, 1'b0);
      checkOutput("hold_valid", 16'(rnd_valid), 16'h0001);
    end

    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("reseed_zero_state", dut.u_lfsr.s, 16'hACE1);
    checkOutput("reseed_valid_drop", 16'(rnd_valid), 16'h0000);
    checkOutput("reseed_warm_drop", 16'(warm), 16'h0000);
    countToValid(40, n);
    checkOutput("reseed_latency", 16'(n), 16'(WARM_CYC));

    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1'($urandom), $urandom_range(0, 63) == 0,
                    ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                    1'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    countToValid(60, n);
    checkOutput("valid_before_reseed_xfer", 16'(rnd_valid), 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("xfer_reseed_valid", 16'(rnd_valid), 16'h0000);
    checkOutput("xfer_reseed_state", 16'(dut.state), 16'(ST_WARMUP));
    checkOutput("xfer_reseed_lfsr", dut.u_lfsr.s, 16'h1234);
    checkOutput("xfer_reseed_warm", 16'(warm), 16'h0000);

    rnd_ready = 1'b1;
    countToValid(40, n);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("in_recharge", 16'(dut.state), 16'(ST_RECHARGE));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 16'(rnd_valid), 16'h0000);
    checkOutput("async_rst_word", rnd_word, 16'h0000);
    checkOutput("async_rst_warm", 16'(warm), 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    rst = 1'b0;
    countToValid(40, n);
    checkOutput("post_reset_latency", 16'(n), 16'(WARM_CYC));
    repeat (3) applyStimulus(1'($urandom), 1'b0, 16'h0000, 1'b1);

    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entropy_prng.md
Name: entropy_prng

Overview:
- Per-lane PRNG at the consumer end of the entropy pool's serial `e_bit` stream.
- Mixes one entropy bit per clock into a Galois LFSR.
- Delivers whitened WIDTH-bit random words to a downstream consumer through a valid/ready handshake.
- Enforces a warm-up period after reset/reseed and a recharge gap between consecutive words, so each word has absorbed fresh entropy.

Parameters:
- WIDTH, 16, LFSR/state and output word width; ≥4.
- TAPS, 16'h002D, Galois feedback mask (x^16+x^5+x^3+x^2+1); WIDTH bits.
- SEED, 16'hACE1, nonzero reset/fallback state; WIDTH bits.
- WARMUP, 16, cycles absorbed after reset or reseed before the first word; ≥1.
- GAP, 4, cycles absorbed after each handshake before the next word; ≥1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- e_bit, input, 1, entropy bit from the pool, sampled every cycle.
- reseed, input, 1, synchronous single-cycle reseed request.
- reseed_word, input, WIDTH, state to load on reseed.
- rnd_valid, output, 1, rnd_word holds a fresh word.
- rnd_ready, input, 1, consumer accepts the word.
- rnd_word, output, WIDTH, random word; stable while rnd_valid=1.
- warm, output, 1, high once the first word has been produced since the last reset/reseed.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - s=SEED, state=WARMUP, cnt=0, rnd_valid=0, rnd_word=0, warm=0.
- LFSR step, every non-reset cycle, in every state:
  - fb=s[WIDTH-1]
  - t = {s[WIDTH-2:0],1'b0} ^ (fb ? TAPS : 0) ^ {0…,e_bit}
  - s_next = (t==0) ? SEED : t (zero-lock guard)
- Handshake:
  - Transfer occurs when rnd_valid & rnd_ready.
  - rnd_word changes only on a capture; it holds otherwise.
  - rnd_ready while rnd_valid=0 is ignored.
  - Consumer may hold rnd_ready high permanently; words then flow once per GAP+1 cycles.
- State machine (cnt sized for max(WARMUP,GAP)):
  - WARMUP: cnt++ each cycle.
    - When cnt==WARMUP-1: rnd_word<=s_next, rnd_valid<=1, warm<=1, cnt<=0, go READY.
    - First valid therefore appears WARMUP cycles after reset release, carrying the state after WARMUP steps.
  - READY: rnd_valid=1.
    - On transfer: rnd_valid<=0, cnt<=0, go RECHARGE.
    - Otherwise stay; the word is held and the LFSR keeps absorbing.
  - RECHARGE: cnt++.
    - When cnt==GAP-1: rnd_word<=s_next, rnd_valid<=1, cnt<=0, go READY.
- Reseed (highest priority among synchronous events):
  - s <= (reseed_word==0) ? SEED : reseed_word. The e_bit of that cycle is discarded.
  - state<=WARMUP, cnt<=0, rnd_valid<=0, warm<=0. rnd_word keeps its last value.
- Reseed simultaneous with a transfer: the transfer counts as completed (consumer keeps the word), then reseed applies.
- Reseed while in WARMUP restarts the warm-up count.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package `prng_pkg`:
  - default WIDTH/TAPS/SEED constants
  - state encoding typedef (WARMUP, READY, RECHARGE)
  - `lfsr_step` function: s, e_bit, TAPS, SEED → s_next
- One natural sub-module, `lfsr_absorb`: the state register plus step/zero-guard/reseed load.
  - entropy_prng wraps it with the FSM, counter and output register.

Test Plan:
- Basic step: WARMUP=1, e_bit=0 held, release reset → one cycle later rnd_valid=1, rnd_word=16'h59EF.
- Entropy injection: same setup with e_bit=1 → rnd_word=16'h59EE; warm=1.
- Handshake and gap:
  - Defaults, rnd_ready=1 held → first rnd_valid 16 cycles after reset release, then one valid cycle every 5 cycles.
  - rnd_word never changes while rnd_valid=1 with rnd_ready=0 held for 20 cycles.
- Zero guard and reseed:
  - reseed=1 with reseed_word=0 → s=16'hACE1; rnd_valid and warm drop next cycle; valid returns 16 cycles later.
  - Model compare against the reference-model LFSR for 1000 random e_bit cycles.
- Simultaneous reseed + transfer:
  - rnd_valid=1, rnd_ready=1, reseed=1, reseed_word=16'h1234 → next cycle rnd_valid=0, state WARMUP, s=16'h1234.
- Async reset mid-RECHARGE:
  - Assert rst between edges → outputs zero immediately, without waiting for a clock edge.
  - After release, behaviour is identical to the power-on sequence.
